// File: rtl/irq_priority_sequencer.sv
// Interrupt sequencer: edge-to-pending capture, mask, winner select, and CPU req/ack/eoi handshake.
// Optional macro IRQ_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed lowest-index priority.
module irq_priority_sequencer #(
  parameter int NUM_IRQ = 4,
  parameter int VEC_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               cpu_ack,
  input  logic               cpu_eoi,
  output logic               cpu_irq,
  output logic [VEC_W-1:0]   irq_vector,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               irq_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [VEC_W-1:0]   vector_q, vector_d;
  logic [VEC_W-1:0]   last_grant_q, last_grant_d;
  logic               cpu_irq_q, cpu_irq_d;
  logic               busy_q, busy_d;

  logic [NUM_IRQ-1:0] irq_edge;
  logic [NUM_IRQ-1:0] eligible;
  logic [VEC_W-1:0]   winner;

  assign irq_edge = irq_in & ~prev_q;
  assign eligible = pending_q & irq_mask;

`ifdef IRQ_ROUND_ROBIN_EN
  // Pick the eligible source with the smallest rotational distance past last_grant.
  always_comb begin
    int best_dist;
    int dist;
    winner    = '0;
    best_dist = NUM_IRQ;
    dist      = 0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      dist = (i + NUM_IRQ - 1 - int'(last_grant_q)) % NUM_IRQ;
      if (eligible[i] && (dist < best_dist)) begin
        best_dist = dist;
        winner    = VEC_W'(i);
      end
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = VEC_W'(i);
      end
    end
  end
`endif

  // An edge arriving in the same cycle as the ack of that source re-arms it.
  always_comb begin
    pending_d = pending_q;
    if ((state_q == REQ) && cpu_ack) begin
      pending_d[vector_q] = 1'b0;
    end
    pending_d = pending_d | irq_edge;
  end

  always_comb begin
    state_d      = state_q;
    vector_d     = vector_q;
    last_grant_d = last_grant_q;
    cpu_irq_d    = cpu_irq_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        cpu_irq_d = 1'b0;
        busy_d    = 1'b0;
        if (|eligible) begin
          vector_d  = winner;
          cpu_irq_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        cpu_irq_d = 1'b1;
        if (cpu_ack) begin
          cpu_irq_d    = 1'b0;
          busy_d       = 1'b1;
          last_grant_d = vector_q;
          state_d      = SERVICE;
        end
      end
      SERVICE: begin
        cpu_irq_d = 1'b0;
        busy_d    = 1'b1;
        if (cpu_eoi) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        cpu_irq_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      pending_q    <= '0;
      vector_q     <= '0;
      last_grant_q <= VEC_W'(NUM_IRQ - 1);
      cpu_irq_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= irq_in;
      pending_q    <= pending_d;
      vector_q     <= vector_d;
      last_grant_q <= last_grant_d;
      cpu_irq_q    <= cpu_irq_d;
      busy_q       <= busy_d;
    end
  end

  // last_grant only ever holds a granted source index.
  assert property (@(posedge clk) disable iff (!rst_n) (int'(last_grant_q) < NUM_IRQ));

  assign cpu_irq     = cpu_irq_q;
  assign irq_vector  = vector_q;
  assign irq_pending = pending_q;
  assign irq_busy    = busy_q;

endmodule

// File: tb/tb_irq_priority_sequencer.sv
// Directed bench for irq_priority_sequencer; expectations follow IRQ_ROUND_ROBIN_EN when defined.
module tb_irq_priority_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] irq_in = 4'b0000;
  logic [3:0] irq_mask = 4'b1111;
  logic       cpu_ack = 1'b0;
  logic       cpu_eoi = 1'b0;
  logic       cpu_irq;
  logic [1:0] irq_vector;
  logic [3:0] irq_pending;
  logic       irq_busy;

  int passed = 0;
  int total  = 0;

  irq_priority_sequencer #(.NUM_IRQ(4), .VEC_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .irq_mask   (irq_mask),
    .cpu_ack    (cpu_ack),
    .cpu_eoi    (cpu_eoi),
    .cpu_irq    (cpu_irq),
    .irq_vector (irq_vector),
    .irq_pending(irq_pending),
    .irq_busy   (irq_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    cpu_eoi = 1'b1;
    tick();
    cpu_eoi = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({cpu_irq, irq_busy, irq_pending, irq_vector} !== 8'h00)
      $display("FAIL reset_async outs=%h exp=00", {cpu_irq, irq_busy, irq_pending, irq_vector});
    else passed++;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if ({cpu_irq, irq_busy, irq_pending} !== 6'h00)
      $display("FAIL reset_release outs=%h exp=00", {cpu_irq, irq_busy, irq_pending});
    else passed++;
    $display("[reset] cpu_irq=%0b busy=%0b pending=%b", cpu_irq, irq_busy, irq_pending);
  endtask

  task automatic test_basic();
    irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000;
    total++;
    if (irq_pending !== 4'b0100 || cpu_irq !== 1'b0)
      $display("FAIL basic_pend pending=%b cpu_irq=%0b exp=0100/0", irq_pending, cpu_irq);
    else passed++;
    tick();
    total++;
    if (cpu_irq !== 1'b1 || irq_vector !== 2'd2)
      $display("FAIL basic_req cpu_irq=%0b vec=%0d exp=1/2", cpu_irq, irq_vector);
    else passed++;
    pulse_ack();
    total++;
    if (irq_pending !== 4'b0000 || irq_busy !== 1'b1 || cpu_irq !== 1'b0)
      $display("FAIL basic_ack pending=%b busy=%0b cpu_irq=%0b exp=0000/1/0", irq_pending, irq_busy, cpu_irq);
    else passed++;
    pulse_eoi();
    total++;
    if (irq_busy !== 1'b0 || cpu_irq !== 1'b0)
      $display("FAIL basic_eoi busy=%0b cpu_irq=%0b exp=0/0", irq_busy, cpu_irq);
    else passed++;
    pulse_ack();
    tick();
    total++;
    if (irq_busy !== 1'b0 || cpu_irq !== 1'b0 || irq_vector !== 2'd2)
      $display("FAIL idle_ack_ignored busy=%0b cpu_irq=%0b vec=%0d exp=0/0/2", irq_busy, cpu_irq, irq_vector);
    else passed++;
    $display("[basic] source 2 delivered, vector held=%0d", irq_vector);
  endtask

  task automatic test_priority();
    logic [1:0] first_v, second_v;
    logic [3:0] pend_mid;
`ifdef IRQ_ROUND_ROBIN_EN
    first_v = 2'd3; second_v = 2'd0; pend_mid = 4'b0001;
`else
    first_v = 2'd0; second_v = 2'd3; pend_mid = 4'b1000;
`endif
    irq_in = 4'b1001;
    tick();
    irq_in = 4'b0000;
    tick();
    total++;
    if (cpu_irq !== 1'b1 || irq_vector !== first_v)
      $display("FAIL prio_first cpu_irq=%0b vec=%0d exp=1/%0d", cpu_irq, irq_vector, first_v);
    else passed++;
    pulse_ack();
    total++;
    if (irq_pending !== pend_mid)
      $display("FAIL prio_pend pending=%b exp=%b", irq_pending, pend_mid);
    else passed++;
    pulse_eoi();
    total++;
    if (cpu_irq !== 1'b0)
      $display("FAIL prio_idle_gap cpu_irq=%0b exp=0", cpu_irq);
    else passed++;
    tick();
    total++;
    if (cpu_irq !== 1'b1 || irq_vector !== second_v)
      $display("FAIL prio_second cpu_irq=%0b vec=%0d exp=1/%0d", cpu_irq, irq_vector, second_v);
    else passed++;
    pulse_ack();
    pulse_eoi();
    $display("[priority] vectors %0d then %0d", first_v, second_v);
  endtask

  task automatic test_mask();
    irq_mask = 4'b1101;
    irq_in   = 4'b0010;
    tick();
    irq_in = 4'b0000;
    tick();
    tick();
    total++;
    if (irq_pending !== 4'b0010 || cpu_irq !== 1'b0)
      $display("FAIL mask_hold pending=%b cpu_irq=%0b exp=0010/0", irq_pending, cpu_irq);
    else passed++;
    irq_mask = 4'b1111;
    tick();
    total++;
    if (cpu_irq !== 1'b1 || irq_vector !== 2'd1)
      $display("FAIL mask_release cpu_irq=%0b vec=%0d exp=1/1", cpu_irq, irq_vector);
    else passed++;
    irq_mask = 4'b0000;
    tick();
    total++;
    if (cpu_irq !== 1'b1 || irq_vector !== 2'd1)
      $display("FAIL mask_in_req cpu_irq=%0b vec=%0d exp=1/1", cpu_irq, irq_vector);
    else passed++;
    irq_mask = 4'b1111;
    pulse_ack();
    pulse_eoi();
    $display("[mask] source 1 held while masked, delivered after unmask");
  endtask

  task automatic test_collision();
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    tick();
    pulse_eoi();
    total++;
    if (cpu_irq !== 1'b1 || irq_busy !== 1'b0 || irq_vector !== 2'd0)
      $display("FAIL req_eoi_ignored cpu_irq=%0b busy=%0b vec=%0d exp=1/0/0", cpu_irq, irq_busy, irq_vector);
    else passed++;
    irq_in  = 4'b0001;
    cpu_ack = 1'b1;
    tick();
    irq_in  = 4'b0000;
    cpu_ack = 1'b0;
    total++;
    if (irq_pending !== 4'b0001 || irq_busy !== 1'b1 || cpu_irq !== 1'b0)
      $display("FAIL collide_set_wins pending=%b busy=%0b cpu_irq=%0b exp=0001/1/0", irq_pending, irq_busy, cpu_irq);
    else passed++;
    pulse_eoi();
    tick();
    total++;
    if (cpu_irq !== 1'b1 || irq_vector !== 2'd0)
      $display("FAIL collide_represent cpu_irq=%0b vec=%0d exp=1/0", cpu_irq, irq_vector);
    else passed++;
    pulse_ack();
    pulse_eoi();
    $display("[collision] source 0 re-presented after eoi");
  endtask

  task automatic test_reset_mid_service();
    irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000;
    tick();
    pulse_ack();
    irq_in = 4'b1000;
    tick();
    irq_in = 4'b0000;
    total++;
    if (irq_pending !== 4'b1000 || irq_busy !== 1'b1 || cpu_irq !== 1'b0)
      $display("FAIL service_edge pending=%b busy=%0b cpu_irq=%0b exp=1000/1/0", irq_pending, irq_busy, cpu_irq);
    else passed++;
    #2;
    rst_n  = 1'b0;
    irq_in = 4'b0010;
    #1;
    total++;
    if ({cpu_irq, irq_busy, irq_pending, irq_vector} !== 8'h00)
      $display("FAIL reset_mid_service outs=%h exp=00", {cpu_irq, irq_busy, irq_pending, irq_vector});
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (irq_pending !== 4'b0010 || cpu_irq !== 1'b0)
      $display("FAIL release_high_edge pending=%b cpu_irq=%0b exp=0010/0", irq_pending, cpu_irq);
    else passed++;
    tick();
    total++;
    if (cpu_irq !== 1'b1 || irq_vector !== 2'd1)
      $display("FAIL release_high_req cpu_irq=%0b vec=%0d exp=1/1", cpu_irq, irq_vector);
    else passed++;
    pulse_ack();
    tick();
    total++;
    if (irq_pending !== 4'b0000)
      $display("FAIL level_no_reedge pending=%b exp=0000", irq_pending);
    else passed++;
    irq_in = 4'b0000;
    pulse_eoi();
    $display("[reset_mid_service] state cleared, high line gave one edge");
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_v [4];
`ifdef IRQ_ROUND_ROBIN_EN
    exp_v = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
    exp_v = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
    #2;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    irq_in = 4'b0011;
    tick();
    irq_in = 4'b0000;
    tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cpu_irq !== 1'b1 || irq_vector !== exp_v[i])
        $display("FAIL grant_%0d cpu_irq=%0b vec=%0d exp=1/%0d", i, cpu_irq, irq_vector, exp_v[i]);
      else passed++;
      $display("[arbitration] grant %0d vector=%0d", i, irq_vector);
      pulse_ack();
      irq_in  = 4'b0011;
      cpu_eoi = 1'b1;
      tick();
      irq_in  = 4'b0000;
      cpu_eoi = 1'b0;
      tick();
    end
    pulse_ack();
    pulse_eoi();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_collision();
    test_reset_mid_service();
    test_round_robin();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
